// File: rtl/pzbcm_packet_arbiter_pkg.sv
// Shared types and helpers for the packet arbiter: FSM state encoding and
// the derived stall-counter width.
package pzbcm_packet_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        TRANSFER = 1'b1
    } pzbcm_packet_arbiter_state;

    // Bits needed to hold values 0..limit, never less than one bit.
    function automatic int calc_stall_width(input int limit);
        int width;
        width = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'd1 << width) < (64'(limit) + 64'd1)) begin
                width = width + 1;
            end else begin
                width = width;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/pzbcm_packet_arbiter_rr_select.sv
// Combinational round-robin picker: first requester strictly after the
// pointer, wrapping around, found by a double-width masked priority encode.
module pzbcm_packet_arbiter_rr_select #(
    parameter int REQUESTS    = 4,
    parameter int INDEX_WIDTH = $clog2(REQUESTS)
) (
    input  logic [REQUESTS-1:0]    i_request,
    input  logic [INDEX_WIDTH-1:0] i_pointer,
    output logic [REQUESTS-1:0]    o_grant,
    output logic [INDEX_WIDTH-1:0] o_index
);

    logic [2*REQUESTS-1:0] masked_s;
    logic                  found_s;
    int                    pos_s;

    // Lower copy keeps only requesters above the pointer; upper copy is the wrap.
    always_comb begin
        masked_s = '0;
        for (int i = 0; i < REQUESTS; i++) begin
            masked_s[i]            = i_request[i] && (i > int'(i_pointer));
            masked_s[i + REQUESTS] = i_request[i];
        end
    end

    // Lowest set bit of the doubled vector, folded back to a source index.
    always_comb begin
        found_s = 1'b0;
        pos_s   = 0;
        for (int i = 0; i < 2 * REQUESTS; i++) begin
            if (masked_s[i] && !found_s) begin
                found_s = 1'b1;
                pos_s   = i;
            end else begin
                found_s = found_s;
            end
        end
        o_index = INDEX_WIDTH'(pos_s % REQUESTS);
        if (found_s) begin
            o_grant = REQUESTS'(1) << o_index;
        end else begin
            o_grant = '0;
        end
    end

endmodule

// File: rtl/pzbcm_packet_arbiter.sv
// Packet-locked round-robin arbiter: shares one valid/ready beat channel among
// REQUESTS sources without interleaving packets, and flags mid-packet stalls.
module pzbcm_packet_arbiter
    import pzbcm_packet_arbiter_pkg::*;
#(
    parameter int REQUESTS    = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int STALL_LIMIT = 0,
    parameter int STALL_WIDTH = calc_stall_width(STALL_LIMIT)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [REQUESTS-1:0]          i_valid,
    output logic [REQUESTS-1:0]          o_ready,
    input  logic [REQUESTS-1:0]          i_last,
    input  logic [REQUESTS*DATA_WIDTH-1:0] i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic                         o_last,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [REQUESTS-1:0]          o_grant,
    output logic                         o_busy,
    output logic                         o_stall
);

    localparam int                     INDEX_WIDTH = $clog2(REQUESTS);
    localparam bit                     STALL_EN    = (STALL_LIMIT > 0);
    localparam logic [STALL_WIDTH-1:0] STALL_MAX   = STALL_WIDTH'(STALL_LIMIT);
    localparam logic [STALL_WIDTH-1:0] STALL_EDGE  = STALL_WIDTH'(STALL_LIMIT - 1);

    pzbcm_packet_arbiter_state state_q, state_d;
    logic [REQUESTS-1:0]       grant_q, grant_d;
    logic [INDEX_WIDTH-1:0]    ptr_q, ptr_d;
    logic [STALL_WIDTH-1:0]    stall_cnt_q, stall_cnt_d;

    logic [REQUESTS-1:0]       pick_grant_s;
    logic [INDEX_WIDTH-1:0]    pick_index_s;
    logic                      sel_valid_s;
    logic                      sel_last_s;
    logic [DATA_WIDTH-1:0]     sel_data_s;

    pzbcm_packet_arbiter_rr_select #(
        .REQUESTS    (REQUESTS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_rr_select (
        .i_request (i_valid),
        .i_pointer (ptr_q),
        .o_grant   (pick_grant_s),
        .o_index   (pick_index_s)
    );

    // The pointer doubles as the locked source index while in TRANSFER.
    always_comb begin
        sel_valid_s = i_valid[ptr_q];
        sel_last_s  = i_last[ptr_q];
        sel_data_s  = i_data[int'(ptr_q) * DATA_WIDTH +: DATA_WIDTH];
    end

    // Next-state, grant lock and downstream/upstream handshake routing.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        o_valid = 1'b0;
        o_last  = 1'b0;
        o_data  = '0;
        o_ready = '0;
        case (state_q)
            IDLE: begin
                if (|i_valid) begin
                    state_d = TRANSFER;
                    grant_d = pick_grant_s;
                    ptr_d   = pick_index_s;
                end else begin
                    state_d = IDLE;
                end
            end
            TRANSFER: begin
                o_valid = sel_valid_s;
                o_last  = sel_last_s;
                o_data  = sel_data_s;
                o_ready = grant_q & {REQUESTS{i_ready}};
                if (sel_valid_s && i_ready && sel_last_s) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else begin
                    state_d = TRANSFER;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Stall counter saturates at the limit so the report fires only once.
    always_comb begin
        o_stall     = 1'b0;
        stall_cnt_d = '0;
        if (STALL_EN && (state_q == TRANSFER) && !sel_valid_s) begin
            o_stall = (stall_cnt_q == STALL_EDGE);
            if (stall_cnt_q != STALL_MAX) begin
                stall_cnt_d = stall_cnt_q + STALL_WIDTH'(1);
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end else begin
            stall_cnt_d = '0;
        end
    end

    // State, grant, pointer and stall counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= INDEX_WIDTH'(REQUESTS - 1);
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_grant = grant_q;
    assign o_busy  = (state_q == TRANSFER);

endmodule
